rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (we3/a3/wd3) between two writers:
//   - P: the in-order pipeline writeback.
//   - L: the long-latency unit (mul/div, load miss).
//  Keeps a busy scoreboard of registers with an outstanding L write, used by the
//  hazard unit to stall readers. Sits between the writeback stage and regfile.
// PARAMETERS
//  XLEN        32  data width of write port
//  REG_AW      5   register address width (2**REG_AW registers)
//  STARVE_MAX  4   cycles L may be refused while valid before it is forced to win
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  reset       in   1       synchronous, active-high reset
//  p_valid     in   1       pipeline write request
//  p_rd        in   REG_AW  pipeline destination register
//  p_wd        in   XLEN    pipeline write data
//  p_ready     out  1       pipeline request accepted this cycle (combinational)
//  l_valid     in   1       long-latency write request
//  l_rd        in   REG_AW  long-latency destination register
//  l_wd        in   XLEN    long-latency write data
//  l_ready     out  1       long-latency request accepted this cycle (combinational)
//  issue_valid in   1       long-latency op issued; mark issue_rd busy
//  issue_rd    in   REG_AW  destination of issued long-latency op
//  busy        out  2**REG_AW  per-register outstanding-L-write flags, bit 0 always 0
//  rf_we       out  1       to regfile we3 (registered)
//  rf_a3       out  REG_AW  to regfile a3 (registered)
//  rf_wd       out  XLEN    to regfile wd3 (registered)
// BEHAVIOUR
//  - Transfer = valid && ready on a rising edge. Requester holds valid/rd/wd until ready.
//  - At most one transfer per cycle. Grant:
//      L wins if l_valid && (!p_valid || starve_cnt == STARVE_MAX); else P wins if p_valid.
//  - p_ready/l_ready depend only on valid inputs and starve_cnt; they never depend on
//    ready. Both are 0 during reset.
//  - Latency: a transfer at edge N drives rf_we=1, rf_a3=rd, rf_wd=wd during cycle N+1.
//    The regfile commits at edge N+1. With no transfer, rf_we=0 the next cycle.
//    rf_a3/rf_wd hold their last values.
//  - rd==0: the transfer completes (ready=1), but rf_we stays 0; x0 is never written.
//  - starve_cnt (saturating, 0..STARVE_MAX):
//      +1 when l_valid && !l_ready;
//      cleared to 0 on an L transfer or when l_valid==0.
//  - Scoreboard, updated at the edge:
//      set busy[issue_rd] if issue_valid && issue_rd!=0;
//      clear busy[l_rd] on an L transfer.
//    Set and clear of the same register in one cycle: set wins (a new op is issued).
//    busy[0] is constant 0.
//  - P and L with the same rd in one cycle: P is granted unless starved. The relative
//    write order is therefore the grant order; the hazard unit prevents WAW via busy.
//  - Reset, including mid-operation: rf_we=0, rf_a3=0, rf_wd=0, starve_cnt=0,
//    busy=0 on the following cycle. Pending requests are dropped; requesters re-present.
// STRUCTURE
//  - Package rf_pkg: XLEN, REG_AW, NREGS=2**REG_AW, STARVE_MAX default,
//    typedef reg_addr_t, typedef xlen_t.
//  - Sub-module rf_scoreboard: busy vector with set/clear ports and set-wins priority.
//  - Grant logic, starve counter and output registers live in rf_wb_arbiter.
// TESTING
//  1. reset=1 for 2 cycles with p_valid=l_valid=1
//       -> p_ready=l_ready=0; after release rf_we=0, busy=0.
//  2. p_valid only, rd=5, wd=0xDEADBEEF
//       -> p_ready=1 same cycle; next cycle rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF.
//  3. p_valid and l_valid held continuously (STARVE_MAX=4)
//       -> P granted 4 cycles, L granted on the 5th, then counter=0 and P resumes.
//  4. issue rd=7, then L write rd=7 three cycles later
//       -> busy[7]=1 from the edge after issue until the edge of the L transfer.
//  5. issue_valid rd=9 in the same cycle as an L transfer to rd=9 -> busy[9] stays 1.
//  6. p_rd=0 and issue_rd=0
//       -> p_ready=1, rf_we stays 0; busy[0] stays 0.
//  7. reset asserted while busy=0x00000480 and L is starving
//       -> next cycle busy=0, starve_cnt=0, rf_we=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and sizing for the register-file writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_pkg;

   localparam int XLEN           = 32;
   localparam int REG_AW         = 5;
   localparam int NREGS          = 2 ** REG_AW;
   localparam int STARVE_MAX_DEF = 4;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]   xlen_t;
   typedef logic [NREGS-1:0]  busy_vec_t;

   // One-hot mask selecting a single register's busy flag.
   function automatic busy_vec_t reg_mask(input reg_addr_t rd);
      busy_vec_t m;
      m = '0;
      m[rd] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of requester, issue, scoreboard and regfile-port signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: ready outputs are driven by the arbiter (slave side).
interface rf_wb_arbiter_if;
   import rf_pkg::*;

   logic      p_valid;
   reg_addr_t p_rd;
   xlen_t     p_wd;
   logic      p_ready;

   logic      l_valid;
   reg_addr_t l_rd;
   xlen_t     l_wd;
   logic      l_ready;

   logic      issue_valid;
   reg_addr_t issue_rd;

   busy_vec_t busy;

   logic      rf_we;
   reg_addr_t rf_a3;
   xlen_t     rf_wd;

   // Arbiter side.
   modport slave (
      input  p_valid, p_rd, p_wd, l_valid, l_rd, l_wd, issue_valid, issue_rd,
      output p_ready, l_ready, busy, rf_we, rf_a3, rf_wd
   );

   // Requester / environment side.
   modport master (
      output p_valid, p_rd, p_wd, l_valid, l_rd, l_wd, issue_valid, issue_rd,
      input  p_ready, l_ready, busy, rf_we, rf_a3, rf_wd
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy flags for registers with an outstanding long-latency write; x0 never busy.
// Latency: set/clear visible the cycle after the edge that applies them.
// Backpressure: none; set wins over clear on the same register.
module rf_scoreboard
   import rf_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      set_en,
   input  reg_addr_t set_rd,
   input  logic      clr_en,
   input  reg_addr_t clr_rd,
   output busy_vec_t busy
);

   busy_vec_t busy_q, busy_d;

   // Next busy vector: clear first so a same-cycle issue to that register re-marks it.
   always_comb begin
      busy_d = busy_q;
      if (clr_en)
         busy_d = busy_d & ~reg_mask(clr_rd);
      if (set_en && (set_rd != '0))
         busy_d = busy_d | reg_mask(set_rd);
      busy_d[0] = 1'b0;
   end

   // Busy state register.
   always_ff @(posedge clk) begin
      if (reset)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the regfile write port between pipeline (P) and long-latency unit (L).
// Latency: a transfer at edge N drives rf_we/rf_a3/rf_wd during cycle N+1.
// Backpressure: P wins ties unless L has been refused STARVE_MAX cycles; ready is combinational.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
)
(
   input  logic             clk,
   input  logic             reset,
   rf_wb_arbiter_if.slave   bus
);

   localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_q, starve_d;
   logic             l_grant, p_grant;
   logic             rf_we_q, rf_we_d;
   reg_addr_t        rf_a3_q, rf_a3_d;
   xlen_t            rf_wd_q, rf_wd_d;
   busy_vec_t        busy_w;

   // Grant: L only when P is idle or L has waited its full allowance; nothing during reset.
   always_comb begin
      l_grant = !reset && bus.l_valid && (!bus.p_valid || (starve_q == STARVE_LIM));
      p_grant = !reset && bus.p_valid && !l_grant;
   end

   assign bus.l_ready = l_grant;
   assign bus.p_ready = p_grant;

   // Starvation count: grows while L is refused, drops to zero when L is served or idle.
   always_comb begin
      starve_d = '0;
      if (bus.l_valid && !l_grant)
         starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 1'b1;
   end

   // Write-port next state: capture the winner; x0 transfers complete without a write.
   always_comb begin
      rf_we_d = 1'b0;
      rf_a3_d = rf_a3_q;
      rf_wd_d = rf_wd_q;
      if (l_grant) begin
         rf_we_d = (bus.l_rd != '0);
         rf_a3_d = bus.l_rd;
         rf_wd_d = bus.l_wd;
      end else if (p_grant) begin
         rf_we_d = (bus.p_rd != '0);
         rf_a3_d = bus.p_rd;
         rf_wd_d = bus.p_wd;
      end
   end

   // Arbiter state and registered regfile port.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q <= '0;
         rf_we_q  <= 1'b0;
         rf_a3_q  <= '0;
         rf_wd_q  <= '0;
      end else begin
         starve_q <= starve_d;
         rf_we_q  <= rf_we_d;
         rf_a3_q  <= rf_a3_d;
         rf_wd_q  <= rf_wd_d;
      end
   end

   assign bus.rf_we = rf_we_q;
   assign bus.rf_a3 = rf_a3_q;
   assign bus.rf_wd = rf_wd_q;

   rf_scoreboard u_scoreboard (
      .clk    (clk),
      .reset  (reset),
      .set_en (bus.issue_valid),
      .set_rd (bus.issue_rd),
      .clr_en (l_grant),
      .clr_rd (bus.l_rd),
      .busy   (busy_w)
   );

   assign bus.busy = busy_w;

endmodule
